// File: rtl/regfile_pkg.sv
// Shared widths, address types and helpers for the
// register-file read side and its scoreboard.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [XLEN-1:0]  xlen_t;
  typedef logic [AW-1:0]    raddr_t;
  typedef logic [NREGS-1:0] regmask_t;

  localparam raddr_t REG_ZERO = '0;

  function automatic regmask_t onehot(raddr_t a);
    onehot = regmask_t'(1) << a;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Issue, operand and write-back bundle between decode,
// the register-file read side and retire.
interface regfile_if;
  import regfile_pkg::*;

  logic     iss_valid;
  logic     iss_ready;
  raddr_t   iss_rs1;
  raddr_t   iss_rs2;
  raddr_t   iss_rd;
  logic     iss_rd_we;
  logic     op_valid;
  xlen_t    op_rs1_data;
  xlen_t    op_rs2_data;
  logic     wb_en;
  raddr_t   wb_addr;
  xlen_t    wb_data;
  regmask_t busy_vec;

  modport master (
    output iss_valid, iss_rs1, iss_rs2,
    output iss_rd, iss_rd_we,
    output wb_en, wb_addr, wb_data,
    input  iss_ready, op_valid,
    input  op_rs1_data, op_rs2_data,
    input  busy_vec
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2,
    input  iss_rd, iss_rd_we,
    input  wb_en, wb_addr, wb_data,
    output iss_ready, op_valid,
    output op_rs1_data, op_rs2_data,
    output busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with same-cycle write-back
// clearing and RAW/WAW issue gating.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     iss_valid,
  input  raddr_t   iss_rs1,
  input  raddr_t   iss_rs2,
  input  raddr_t   iss_rd,
  input  logic     iss_rd_we,
  input  logic     wb_en,
  input  raddr_t   wb_addr,
  output logic     iss_ready,
  output regmask_t busy_vec
);

  regmask_t busy_q;
  regmask_t busy_d;
  regmask_t wb_hit;
  regmask_t eff_busy;
  logic     accept;

  always_comb begin
    wb_hit   = wb_en ? onehot(wb_addr) : '0;
    eff_busy = busy_q & ~wb_hit;
    iss_ready = !eff_busy[iss_rs1]
             && !eff_busy[iss_rs2]
             && !(iss_rd_we && eff_busy[iss_rd]);
    accept = iss_valid && iss_ready;
    busy_d = eff_busy;
    // set applied after clear: a new producer wins
    if (accept && iss_rd_we && iss_rd != REG_ZERO)
      busy_d = busy_d | onehot(iss_rd);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_reader.sv
// Register storage, write-back bypass and registered
// operand outputs for two-source issue.
module regfile_reader
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  xlen_t mem [NREGS];
  xlen_t rs1_val;
  xlen_t rs2_val;
  xlen_t op1_q;
  xlen_t op2_q;
  logic  op_valid_q;
  logic  accept;

  regfile_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_rs1   (bus.iss_rs1),
    .iss_rs2   (bus.iss_rs2),
    .iss_rd    (bus.iss_rd),
    .iss_rd_we (bus.iss_rd_we),
    .wb_en     (bus.wb_en),
    .wb_addr   (bus.wb_addr),
    .iss_ready (bus.iss_ready),
    .busy_vec  (bus.busy_vec)
  );

  assign accept = bus.iss_valid && bus.iss_ready;

  always_comb begin
    rs1_val = mem[bus.iss_rs1];
    if (bus.wb_en && bus.wb_addr == bus.iss_rs1)
      rs1_val = bus.wb_data;
    if (bus.iss_rs1 == REG_ZERO)
      rs1_val = '0;
    rs2_val = mem[bus.iss_rs2];
    if (bus.wb_en && bus.wb_addr == bus.iss_rs2)
      rs2_val = bus.wb_data;
    if (bus.iss_rs2 == REG_ZERO)
      rs2_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != REG_ZERO) begin
      mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else begin
      op_valid_q <= accept;
      if (accept) begin
        op1_q <= rs1_val;
        op2_q <= rs2_val;
      end
    end
  end

  assign bus.op_valid    = op_valid_q;
  assign bus.op_rs1_data = op1_q;
  assign bus.op_rs2_data = op2_q;

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Read side of the RISC-V integer register file. Serves two source-operand reads per issue and keeps a per-register busy scoreboard so that no instruction reads a value with a write-back still pending. It sits between decode (issue requests) and execute (operands). It accepts write-backs from the retire stage, which supplies the enable-gated 32-bit write path into the register storage.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural registers; x0 hardwired to zero
- AW, 5, register address width, log2(NREGS)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  decode presents an instruction
- iss_ready  out  1  issue accepted this cycle (combinational)
- iss_rs1  in  AW  source 1 address
- iss_rs2  in  AW  source 2 address
- iss_rd  in  AW  destination address
- iss_rd_we  in  1  instruction will write iss_rd
- op_valid  out  1  operands valid (one-cycle pulse per accepted issue)
- op_rs1_data  out  XLEN  source 1 value
- op_rs2_data  out  XLEN  source 2 value
- wb_en  in  1  write-back strobe
- wb_addr  in  AW  write-back address
- wb_data  in  XLEN  write-back value
- busy_vec  out  NREGS  current scoreboard, for debug and verification

## Operation
- Storage: NREGS x XLEN flops. Reads from x0 return 0. Writes to x0 are ignored.
- The scoreboard tracks one busy bit per register. busy[0] is constant 0.
- Effective busy bit eff_busy[r] = busy[r] && !(wb_en && wb_addr==r). A write-back clears the hazard in the same cycle.
- iss_ready = !eff_busy[iss_rs1] && !eff_busy[iss_rs2] && !(iss_rd_we && eff_busy[iss_rd]).
  - RAW and WAW stalls only; no WAR hazard exists with in-order issue.
- Accept = iss_valid && iss_ready. On accept:
  - Operands are latched into op_rs*_data.
  - op_valid is set for one cycle.
  - If iss_rd_we && iss_rd!=0, busy[iss_rd] is set.
- Write-back bypass: if wb_en && wb_addr==rsN && rsN!=0 in the accept cycle, op_rsN_data takes wb_data, not stored data.
- Write-back: on wb_en && wb_addr!=0, mem[wb_addr] <= wb_data and busy[wb_addr] is cleared.
- Same-cycle set and clear on one address (accept with iss_rd==wb_addr): the set wins, and busy stays 1 for the new producer.
- A write-back to a non-busy register is legal; it updates storage and leaves busy at 0.
- When not accepted, op_valid=0 and op_rs*_data hold their previous value.

## Timing
- Reset (async assert, sync-released by the system): all storage 0, busy_vec 0, op_valid 0, op_rs1_data 0, op_rs2_data 0.
- Reset mid-operation discards every pending busy bit and any in-flight operand.
- Operand latency is 1 cycle. Operands and op_valid are registered at the clk edge that accepts the issue.
- iss_ready is combinational from the iss_* and wb_* inputs and the busy bits. It must not depend on iss_valid.
- Back-to-back issues are sustained at 1 per cycle when there are no hazards.
- A write-back becomes readable through storage 1 cycle after wb_en. In its own cycle it is visible only through the bypass.
- Decode must hold iss_* stable while iss_valid && !iss_ready.

## Structure
- Shared package regfile_pkg: XLEN, NREGS, AW, and the constant REG_ZERO=0.
- One natural sub-module, regfile_scoreboard: busy bits, the set/clear priority, and eff_busy/iss_ready generation.
- The top instantiates the scoreboard and holds the storage array, bypass muxes and operand registers.

## Test plan
- Reset then read: write x5=0xDEADBEEF, then issue rs1=5, rs2=0 -> next cycle op_valid=1, op_rs1_data=0xDEADBEEF, op_rs2_data=0.
- RAW stall: issue rd=7 with rd_we, then issue rs1=7 -> iss_ready=0 until wb_en to x7 with 0x1234.
  - In the write-back cycle the issue is accepted, and op_rs1_data=0x1234 through the bypass.
- WAW: x3 busy; issue rd=3 with rd_we and unrelated sources -> stall until write-back to x3.
  - Same-cycle accept then leaves busy_vec[3]=1.
- x0 rules: wb_en to x0 with 0xFFFFFFFF, then read x0 -> 0.
  - Issue rd=0 with rd_we -> busy_vec stays 0 and the next issue is not stalled.
- Throughput: 8 hazard-free issues on consecutive cycles -> 8 consecutive op_valid pulses with correct data.
- Reset mid-operation: x4 and x9 busy, assert rst_n=0 for one cycle -> busy_vec=0, op_valid=0, all registers read 0.
